// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: FSM encoding,
// slice width and the slice-index width rule.
package wide_add_seq_pkg;

  localparam int WADD_SLICE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2(words) but never narrower than one bit, so WORDS=1 still has an index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_csa32.sv
// csa32_nov: combinational 32-bit carry-select adder slice.
// Two 16-bit halves; the upper half is precomputed for both carry-in values.
module csa32_nov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  // Lower half ripples from cin; its carry selects the matching upper-half result.
  always_comb begin
    lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'd0, cin};
    hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    if (lo[16]) begin
      sum  = {hi1[15:0], lo[15:0]};
      cout = hi1[16];
    end else begin
      sum  = {hi0[15:0], lo[15:0]};
      cout = hi0[16];
    end
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle W-bit add/subtract: one 32-bit slice per cycle, LSW first, carry chained
// through a register. Define WADD_SAT_EN to saturate out_sum on signed overflow.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = WADD_SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int            IW       = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic                     sub;
  logic [W-1:0]             a_q;
  logic [W-1:0]             b_q;
  logic [W-1:0]             sum;
  logic                     cout;
  logic                     ovf;
  logic                     valid;
  logic                     ready;

  logic [WADD_SLICE_W-1:0]  din1;
  logic [WADD_SLICE_W-1:0]  din2;
  logic                     cin;
  logic [WADD_SLICE_W-1:0]  slice_sum;
  logic                     slice_cout;
  logic                     last;
  logic                     ovf_next;
  logic [W-1:0]             sum_next;
  logic [W-1:0]             sum_final;

  csa32_nov u_csa (
    .a    (din1),
    .b    (din2),
    .cin  (cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Slice mux and next-sum assembly; overflow is judged on the top slice's MSB.
  always_comb begin
    din1      = a_q[int'(idx) * WADD_SLICE_W +: WADD_SLICE_W];
    din2      = b_q[int'(idx) * WADD_SLICE_W +: WADD_SLICE_W] ^ {WADD_SLICE_W{sub}};
    cin       = (idx == {IW{1'b0}}) ? sub : carry;
    last      = (idx == LAST_IDX);
    sum_next  = sum;
    sum_next[int'(idx) * WADD_SLICE_W +: WADD_SLICE_W] = slice_sum;
    ovf_next  = (a_q[W-1] == (b_q[W-1] ^ sub)) & (slice_sum[WADD_SLICE_W-1] != a_q[W-1]);
`ifdef WADD_SAT_EN
    if (ovf_next) begin
      sum_final = {a_q[W-1], {(W-1){~a_q[W-1]}}};
    end else begin
      sum_final = sum_next;
    end
`else
    sum_final = sum_next;
`endif
  end

  // Sequencer FSM with registered handshake flags and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= {IW{1'b0}};
      carry <= 1'b0;
      sub   <= 1'b0;
      a_q   <= {W{1'b0}};
      b_q   <= {W{1'b0}};
      sum   <= {W{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      ready <= 1'b1;
    end else if (flush) begin
      state <= IDLE;
      idx   <= {IW{1'b0}};
      carry <= 1'b0;
      sum   <= {W{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sub   <= in_sub;
            idx   <= {IW{1'b0}};
            ready <= 1'b0;
            state <= RUN;
          end else begin
            ready <= 1'b1;
          end
        end
        RUN: begin
          carry <= slice_cout;
          if (last) begin
            sum   <= sum_final;
            cout  <= slice_cout;
            ovf   <= ovf_next;
            idx   <= {IW{1'b0}};
            valid <= 1'b1;
            state <= DONE;
          end else begin
            sum   <= sum_next;
            idx   <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            valid <= 1'b1;
          end
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = ready;
  assign out_valid = valid;
  assign out_sum   = sum;
  assign out_cout  = cout;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed + random bench for wide_add_seq (WORDS=4) with an expected-result scoreboard.
module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  res_t got;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] be;
    res_t         r;
    be     = b ^ {W{sub}};
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
`ifdef WADD_SAT_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", W'(in_ready), W'(1));
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    sb.push_back(model(a, b, sub));
    tick();
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom, $urandom, $urandom};
    in_b     = {$urandom, $urandom, $urandom, $urandom};
    in_sub   = ~sub;
    check("busy_after_accept", W'(in_ready), W'(0));
  endtask

  task automatic finish_op(input int hold, output res_t r);
    int   n = 0;
    res_t e;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", W'(n), W'(WORDS));
    check("out_valid", W'(out_valid), W'(1));
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", W'(0), W'(1));
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("sum", out_sum, e.sum);
    check("cout", W'(out_cout), W'(e.cout));
    check("ovf", W'(out_ovf), W'(e.ovf));
    r = {out_sum, out_cout, out_ovf};
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_sum", out_sum, e.sum);
      check("hold_cout_ovf", W'({out_cout, out_ovf}), W'({e.cout, e.ovf}));
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", W'(out_valid), W'(0));
    check("release_ready", W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         seen;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_sum", out_sum, W'(0));
    check("rst_flags", W'({out_cout, out_ovf}), W'(0));
    check("rst_ready", W'(in_ready), W'(1));
    rst = 1'b0;
    tick();

    // carry chain across three slices
    start_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
    finish_op(0, got);
    check("chain_sum", got.sum, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
    check("chain_flags", W'({got.cout, got.ovf}), W'(0));

    // subtract with borrow, then equal operands
    start_op(128'd0, 128'd1, 1'b1);
    finish_op(0, got);
    check("borrow_sum", got.sum, {W{1'b1}});
    check("borrow_flags", W'({got.cout, got.ovf}), W'(0));
    start_op(128'd5, 128'd5, 1'b1);
    finish_op(0, got);
    check("eq_sum", got.sum, W'(0));
    check("eq_cout", W'(got.cout), W'(1));

    // signed overflow, with 3 cycles of backpressure in DONE
    start_op({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0);
    finish_op(3, got);
    check("ovf_flag", W'(got.ovf), W'(1));
`ifdef WADD_SAT_EN
    check("ovf_sum", got.sum, {1'b0, {(W-1){1'b1}}});
`else
    check("ovf_sum", got.sum, {1'b1, {(W-1){1'b0}}});
`endif
    // next op accepted right after release
    check("post_release_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      start_op(a, b, i[0]);
      finish_op(i % 2, got);
    end

    // asynchronous reset mid-RUN
    start_op(128'h1234_5678_9ABC_DEF0_1111_2222_3333_4444, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", W'(out_valid), W'(0));
    check("midrst_sum", out_sum, W'(0));
    check("midrst_ready", W'(in_ready), W'(1));
    void'(sb.pop_back());
    tick();
    rst = 1'b0;
    tick();
    start_op(128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000, 128'h0000_0001_0000_0001_0000_0001_0000_0001, 1'b1);
    finish_op(0, got);

    // flush after two RUN cycles
    start_op(128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", W'(in_ready), W'(1));
    check("flush_valid", W'(out_valid), W'(0));
    check("flush_sum", out_sum, W'(0));
    check("flush_flags", W'({out_cout, out_ovf}), W'(0));
    void'(sb.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("flush_no_valid", W'(seen), W'(0));

    // flush with in_valid in IDLE: nothing accepted
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 128'd7;
    in_b     = 128'd9;
    in_sub   = 1'b0;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_ready", W'(in_ready), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid | ~in_ready;
    end
    check("flush_accept_idle", W'(seen), W'(0));

    start_op(128'd7, 128'd9, 1'b0);
    finish_op(0, got);
    check("final_sum", got.sum, 128'd16);
    check("scoreboard_empty", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
